rv32e_fetch_unit: RTL
=====================

// Module: rv32e_fetch_unit
// PURPOSE
//   Instruction-fetch initiator for the RV32E core; drives the program bus toward the program ROM.
//   Issues sequential word addresses and captures the returned instruction words.
//   Buffers the words in a DEPTH-entry prefetch FIFO and hands {pc, instr} to decode over valid/ready.
//   Flushes the FIFO and re-steers fetch on a branch/jump redirect.
// PARAMETERS
//   RESET_PC  32'h0000_0000  fetch address loaded on reset
//   DEPTH     4              prefetch FIFO entries; power of 2, >= 2
// PORTS
//   clk               in   1   system clock, rising edge
//   reset             in   1   asynchronous, active-low reset (0 = in reset)
//   program_addr_bus  out  32  fetch byte address to program ROM
//   program_data_bus  in   32  instruction word; combinational response to program_addr_bus, same cycle
//   redirect_valid    in   1   1 = discard prefetched words and fetch from redirect_pc
//   redirect_pc       in   32  new fetch address; bits [1:0] ignored (forced 00)
//   instr_valid       out  1   FIFO head holds a valid instruction
//   instr_ready       in   1   decode accepts head this cycle
//   instr_data        out  32  head instruction word; 0 when instr_valid=0
//   instr_pc          out  32  address of head instruction; 0 when instr_valid=0
// BEHAVIOUR
//   Reset (async assert, any time, including mid-operation):
//   - fetch_pc = RESET_PC; count = 0; rd_ptr = wr_ptr = 0.
//   - instr_valid = 0 and instr_data/instr_pc = 0 immediately, not at the next edge.
//   - program_addr_bus = RESET_PC.
//   - Reset release takes effect at the first rising edge with reset=1.
//   Address path: program_addr_bus = fetch_pc, driven directly from a register (no combinational path from inputs).
//   Push: push = !redirect_valid && (count < DEPTH || pop).
//   - On push, store {fetch_pc, program_data_bus} at wr_ptr; wr_ptr++; fetch_pc += 4.
//   Pop: pop = instr_valid && instr_ready && !redirect_valid.
//   - On pop, rd_ptr++.
//   Count update: count += push - pop. Push and pop in the same cycle leave count unchanged.
//   - At count = DEPTH, push is allowed only if a pop occurs in the same cycle (no overflow, no stall bubble).
//   - At count = 0, no pop is possible. No bypass: a word pushed at edge N is visible at instr_* only after edge N.
//   Latency:
//   - Earliest instr_valid=1 is the cycle after the first post-reset edge.
//   - Steady state with instr_ready=1: one instruction per cycle, pcs increasing by 4.
//   Redirect (highest priority after reset):
//   - At the edge, count = 0, pointers = 0, fetch_pc = {redirect_pc[31:2], 2'b00}.
//   - No push and no pop that cycle; the head is not consumed even if instr_ready=1.
//   - Next cycle: program_addr_bus = new pc and instr_valid = 0.
//   - First new instruction becomes valid one cycle after that.
//   - Back-to-back redirects: the last one wins; nothing is fetched between them.
//   Arithmetic: fetch_pc is 32-bit modulo, so 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 silently.
//   - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
//   Derived occupancy states (no separate FSM register):
//   - EMPTY (count = 0), PARTIAL, FULL (count = DEPTH).
//   - instr_valid = (count != 0).
//   - Transitions follow the push/pop/redirect rules above.
//   Stability: instr_data and instr_pc hold stable while instr_valid=1 and instr_ready=0.
// TESTING
//   T1 Reset, ROM word = addr^32'hA5A5_0000, instr_ready=1:
//      instr_pc = 0,4,8,C on consecutive cycles starting 1 cycle after release; data matches.
//   T2 instr_ready=0 for 10 cycles:
//      count saturates at 4; program_addr_bus holds 0x10; head stays pc=0.
//      Raise ready: pcs 0,4,8,C,10 follow with no gap.
//   T3 redirect_valid=1, redirect_pc=32'h0000_0103 while FULL:
//      next cycle instr_valid=0 and program_addr_bus=0x100.
//      Following cycle instr_pc=0x100; old entries never appear.
//   T4 Two redirects back to back (0x200, then 0x300):
//      only 0x300,0x304,... are delivered.
//   T5 RESET_PC=32'hFFFF_FFF8, ready=1:
//      instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
//   T6 Assert reset mid-stream with the FIFO half full:
//      instr_valid drops to 0 within the same cycle (before the next edge).
//      After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/rv32e_fetch_unit_if.sv
// Program-bus and decode-side handshake bundle for the RV32E fetch unit.
// master = fetch unit, slave = ROM/decode environment.
interface rv32e_fetch_unit_if;
    logic [31:0] program_addr_bus;
    logic [31:0] program_data_bus;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    modport master (
        output program_addr_bus,
        input  program_data_bus,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  program_addr_bus,
        output program_data_bus,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/rv32e_fetch_unit.sv
// RV32E instruction fetch: sequential word fetch into a DEPTH-entry prefetch FIFO,
// delivering {pc, instr} over valid/ready, with flush-and-resteer on redirect.
module rv32e_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic                clk,
    input logic                reset,
    rv32e_fetch_unit_if.master bus
);

    localparam int unsigned    PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic head_valid;
    logic push;
    logic pop;

    // Low address bits of a redirect target are dropped by word alignment.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    assign head_valid = (count_q != '0);

    always_comb begin
        pop        = head_valid && bus.instr_ready && !bus.redirect_valid;
        push       = !bus.redirect_valid && ((count_q < FULL_CNT) || pop);
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            data_mem[wr_ptr_q] <= bus.program_data_bus;
        end
    end

    assign bus.program_addr_bus = fetch_pc_q;
    assign bus.instr_valid      = head_valid;
    assign bus.instr_data       = head_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign bus.instr_pc         = head_valid ? pc_mem[rd_ptr_q]   : 32'h0;

endmodule
